// File: rtl/display_pacer.sv
// Character pacing stage between the CPU display register and the display terminal block.
// CPU writes queue in a FIFO; a sequencer replays each character with a strobe, a re-arm gap and a rate limit.
module display_pacer #(
  parameter int DEPTH      = 16,
  parameter int PACE_DIV   = 233333,
  parameter int STROBE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cs,
  input  logic       cpu_en,
  input  logic       cpu_we,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       clr_screen,
  output logic       disp_address,
  output logic       disp_enable,
  output logic       disp_w_en,
  output logic [7:0] disp_din
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (PACE_DIV > 2) ? $clog2(PACE_DIV) : 1;
  localparam int SW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

  localparam logic [PW-1:0] PACE_LAST   = PW'(PACE_DIV - 1);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_LEN - 1);
  localparam logic [SW-1:0] GAP_LAST    = SW'(1);
  localparam logic [5:0]    FULL_COUNT  = 6'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [5:0]      count;
  logic            ovf;
  logic [7:0]      last_char;
  logic [SW-1:0]   step_cnt;
  logic [PW-1:0]   pace_cnt;
  logic [PW-1:0]   pace_nxt;
  logic            pace_done;

  logic            bus_acc;
  logic            data_wr;
  logic            ctrl_wr;
  logic            flush;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // clr_screen masks every CPU access in its cycle, so it can be folded into the bus qualifier
  assign bus_acc = cpu_cs & cpu_en & ~clr_screen;
  assign data_wr = bus_acc & cpu_we & ~cpu_addr;
  assign ctrl_wr = bus_acc & cpu_we & cpu_addr;
  assign flush   = ctrl_wr & cpu_din[0];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == 6'd0);
  assign push    = data_wr & ~full;

  assign pace_nxt  = (pace_cnt >= PACE_LAST) ? pace_cnt : pace_cnt + PW'(1);
  assign pace_done = (pace_nxt >= PACE_LAST);

  assign cpu_dout = cpu_addr ? {empty, ovf, 1'b0, count[4:0]}
                             : {full, last_char[6:0]};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cpu_din;
    end
  end

  // Fullness is judged before the edge, so a same-cycle pop never makes room for a push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 6'd0;
      ovf       <= 1'b0;
      last_char <= 8'h00;
    end else if (clr_screen || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 6'd0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        last_char <= cpu_din;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
      if (data_wr && full) begin
        ovf <= 1'b1;
      end else if (ctrl_wr) begin
        ovf <= 1'b0;
      end
    end
  end

  // GAP may skip WAIT when the pace interval has already elapsed, giving the short-period floor
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !clr_screen && !flush) begin
          pop       = 1'b1;
          state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        if (clr_screen || step_cnt == STROBE_LAST) begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (step_cnt == GAP_LAST) begin
          state_nxt = pace_done ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (clr_screen || pace_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Display-side outputs are registered from the next state so they change exactly with it
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt     <= '0;
      pace_cnt     <= '0;
      disp_address <= 1'b1;
      disp_enable  <= 1'b0;
      disp_w_en    <= 1'b0;
      disp_din     <= 8'h00;
    end else begin
      if (state_nxt != state) begin
        step_cnt <= '0;
      end else if (state == S_STROBE || state == S_GAP) begin
        step_cnt <= step_cnt + SW'(1);
      end
      pace_cnt <= pop ? '0 : pace_nxt;
      if (pop) begin
        disp_din <= mem[rd_ptr];
      end
      disp_address <= (state_nxt == S_IDLE) || (state_nxt == S_WAIT);
      disp_enable  <= (state_nxt == S_STROBE);
      disp_w_en    <= (state_nxt == S_STROBE);
    end
  end

endmodule

// File: tb/tb_display_pacer.sv
// Directed bench for display_pacer with DEPTH=4, PACE_DIV=20, STROBE_LEN=4.
// Steps run linearly; inputs change and outputs are sampled on the falling clock edge.
module tb_display_pacer;

  logic       clk;
  logic       rst;
  logic       cpu_cs;
  logic       cpu_en;
  logic       cpu_we;
  logic       cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       clr_screen;
  logic       disp_address;
  logic       disp_enable;
  logic       disp_w_en;
  logic [7:0] disp_din;

  int checks = 0;
  int errors = 0;

  display_pacer #(
    .DEPTH(4),
    .PACE_DIV(20),
    .STROBE_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_cs(cpu_cs),
    .cpu_en(cpu_en),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .clr_screen(clr_screen),
    .disp_address(disp_address),
    .disp_enable(disp_enable),
    .disp_w_en(disp_w_en),
    .disp_din(disp_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic cs, input logic en, input logic we,
                               input logic addr, input logic [7:0] din);
    cpu_cs   = cs;
    cpu_en   = en;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cpuWrite(input logic addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, 1'b1, addr, data);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic readCheck(input logic addr, input logic [7:0] expected, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, addr, 8'h00);
    #1;
    checkOutput(tag, 16'(cpu_dout), 16'(expected));
  endtask

  task automatic checkDisp(input string tag, input logic addr, input logic en,
                           input logic [7:0] din);
    checkOutput({tag, "_addr"}, 16'(disp_address), 16'(addr));
    checkOutput({tag, "_en"}, 16'(disp_enable), 16'(en));
    checkOutput({tag, "_wen"}, 16'(disp_w_en), 16'(en));
    checkOutput({tag, "_din"}, 16'(disp_din), 16'(din));
  endtask

  task automatic waitStrobe(input string tag);
    int n;
    n = 0;
    while (disp_enable === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (disp_enable !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, (n < 40) ? 16'd1 : 16'd0, 16'd1);
  endtask

  initial begin
    logic saw_strobe;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    clr_screen = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    readCheck(1'b0, 8'h00, "rst_data");
    readCheck(1'b1, 8'h80, "rst_status");
    checkDisp("rst", 1'b1, 1'b0, 8'h00);

    $display("[TB] single character latency and strobe shape");
    cpuWrite(1'b0, 8'hC1);
    readCheck(1'b1, 8'h01, "single_status_queued");
    checkDisp("single_pre", 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    checkDisp("single_s0", 1'b0, 1'b1, 8'hC1);
    readCheck(1'b1, 8'h80, "single_status_popped");
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checkDisp("single_strobe", 1'b0, 1'b1, 8'hC1);
    end
    @(negedge clk);
    checkDisp("single_gap0", 1'b0, 1'b0, 8'hC1);
    @(negedge clk);
    checkDisp("single_gap1", 1'b0, 1'b0, 8'hC1);
    @(negedge clk);
    checkDisp("single_wait", 1'b1, 1'b0, 8'hC1);
    readCheck(1'b0, 8'h41, "single_data_read");
    repeat (20) @(negedge clk);

    $display("[TB] burst of three and pacing interval");
    cpuWrite(1'b0, 8'hC1);
    readCheck(1'b1, 8'h01, "burst_cnt_a");
    cpuWrite(1'b0, 8'hC2);
    readCheck(1'b1, 8'h01, "burst_cnt_b");
    checkDisp("burst_first", 1'b0, 1'b1, 8'hC1);
    cpuWrite(1'b0, 8'hC3);
    readCheck(1'b1, 8'h02, "burst_cnt_c");
    repeat (18) @(negedge clk);
    checkDisp("burst_before2", 1'b1, 1'b0, 8'hC1);
    @(negedge clk);
    checkDisp("burst_second", 1'b0, 1'b1, 8'hC2);
    readCheck(1'b1, 8'h01, "burst_cnt_d");
    repeat (19) @(negedge clk);
    checkOutput("burst_before3_en", 16'(disp_enable), 16'd0);
    @(negedge clk);
    checkDisp("burst_third", 1'b0, 1'b1, 8'hC3);
    readCheck(1'b1, 8'h80, "burst_cnt_e");

    $display("[TB] overflow while stalled in WAIT");
    repeat (8) @(negedge clk);
    cpuWrite(1'b0, 8'hD0);
    cpuWrite(1'b0, 8'hD1);
    cpuWrite(1'b0, 8'hD2);
    cpuWrite(1'b0, 8'hD3);
    readCheck(1'b1, 8'h04, "ovf_full_status");
    cpuWrite(1'b0, 8'hD4);
    cpuWrite(1'b0, 8'hD5);
    readCheck(1'b0, 8'hD3, "ovf_data_busy");
    readCheck(1'b1, 8'h44, "ovf_status");
    cpuWrite(1'b1, 8'h00);
    readCheck(1'b1, 8'h04, "ovf_cleared");

    $display("[TB] clr_screen during a strobe");
    repeat (5) @(negedge clk);
    checkDisp("clr_pop", 1'b0, 1'b1, 8'hD0);
    readCheck(1'b1, 8'h03, "clr_queued");
    @(negedge clk);
    checkOutput("clr_strobe_en", 16'(disp_enable), 16'd1);
    clr_screen = 1'b1;
    @(negedge clk);
    clr_screen = 1'b0;
    checkDisp("clr_gap0", 1'b0, 1'b0, 8'hD0);
    readCheck(1'b1, 8'h80, "clr_status");
    @(negedge clk);
    checkDisp("clr_gap1", 1'b0, 1'b0, 8'hD0);
    @(negedge clk);
    checkDisp("clr_after", 1'b1, 1'b0, 8'hD0);
    saw_strobe = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (disp_enable !== 1'b0) saw_strobe = 1'b1;
    end
    checkOutput("clr_no_strobe", 16'(saw_strobe), 16'd0);
    readCheck(1'b1, 8'h80, "clr_status_late");

    $display("[TB] pointer wrap over ten characters");
    cpuWrite(1'b0, 8'h80);
    cpuWrite(1'b0, 8'h81);
    cpuWrite(1'b0, 8'h82);
    cpuWrite(1'b0, 8'h83);
    checkDisp("wrap_0", 1'b0, 1'b1, 8'h80);
    readCheck(1'b1, 8'h03, "wrap_cnt");
    for (int i = 1; i < 10; i++) begin
      waitStrobe("wrap_wait");
      checkOutput("wrap_din", 16'(disp_din), 16'(8'h80 + 8'(i)));
      if (i + 3 <= 9) cpuWrite(1'b0, 8'h80 + 8'(i + 3));
    end
    readCheck(1'b1, 8'h80, "wrap_empty");
    readCheck(1'b0, 8'h09, "wrap_last_char");

    $display("[TB] reset in the middle of a strobe");
    repeat (25) @(negedge clk);
    cpuWrite(1'b0, 8'h55);
    @(negedge clk);
    checkDisp("mid_strobe", 1'b0, 1'b1, 8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkDisp("mid_rst", 1'b1, 1'b0, 8'h00);
    readCheck(1'b1, 8'h80, "mid_rst_status");
    readCheck(1'b0, 8'h00, "mid_rst_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
